dma_block_engine: RTL and testbench
===================================

Name: dma_block_engine

Overview:
- Responder end of the 1024-bit block DMA interface driven by the RSA coprocessor (rx_start/tx_start, done, idle, error).
- Serves one block at a time:
  - RX: fetches a 1024-bit block from memory as 32 sequential 32-bit word reads.
  - TX: writes a 1024-bit block as 32 sequential word writes.
- Sits between the coprocessor and the system memory port.

Parameters:
- DATA_W, 1024, block width in bits.
- BUS_W, 32, memory word width; BEATS = DATA_W/BUS_W = 32 (derived, not overridable).
- TIMEOUT, 1024, max cycles to wait for mem_gnt or mem_rvalid before aborting.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_start  in  1  start block read (single-cycle pulse).
- rx_address  in  32  byte address of block to read.
- rx_data  out  1024  last block read; beat k in bits [32k+31:32k].
- tx_start  in  1  start block write (single-cycle pulse).
- tx_address  in  32  byte address of block to write.
- tx_data  in  1024  block to write, sampled at start.
- done  out  1  one-cycle completion pulse (success or abort).
- idle  out  1  engine ready to accept a start.
- error  out  1  sticky error flag for the last transfer.
- mem_req  out  1  word request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word byte address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- mem_err  in  1  bus error, qualified by mem_gnt (writes) or mem_rvalid (reads).

Behaviour:
- Reset values:
  - idle = 1; done = 0; error = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; rx_data = 0.
  - State IDLE; beat counter = 0; timeout counter = 0.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous), no done pulse.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE:
  - rx_start has priority. rx_start = 1 latches base = {rx_address[31:2], 2'b00} and clears error, then goes to RD_REQ.
  - Else tx_start = 1 latches base likewise, latches tx_data into the shift buffer and clears error, then goes to WR_REQ.
  - A simultaneous tx_start is dropped.
  - Starts arriving in any other state are ignored.
- idle:
  - Deasserts the cycle after start acceptance (registered).
  - Reasserts in the FINISH cycle.
- RD_REQ:
  - Drives mem_req = 1, mem_we = 0, mem_addr = base + 4*k (mod 2^32, wraps silently).
  - mem_req and mem_addr are held until mem_gnt.
  - On mem_gnt goes to RD_WAIT.
- RD_WAIT:
  - On mem_rvalid, captures mem_rdata into the internal buffer slot k.
  - If k = BEATS-1, goes to FINISH; else k++ and returns to RD_REQ.
  - One outstanding read at most.
- WR_REQ:
  - Drives mem_req = 1, mem_we = 1, mem_addr = base + 4*k, mem_wdata = buffer word k.
  - On mem_gnt, if k = BEATS-1 goes to FINISH; else k++ and stays in WR_REQ.
  - Back-to-back beats are allowed.
- FINISH (1 cycle):
  - done = 1, idle = 1, mem_req = 0; then goes to IDLE.
  - rx_data is updated from the buffer only in the cycle entering FINISH after a successful read. It is stable otherwise, and valid when done is sampled.
- Error/abort:
  - Triggers: mem_err on a qualifying beat, or the timeout counter reaching TIMEOUT in RD_REQ, RD_WAIT or WR_REQ.
  - Effect: error = 1, transfer aborts to FINISH (done still pulses), rx_data is not updated.
  - The timeout counter resets on every mem_gnt/mem_rvalid and on state entry.
- error stays set until the next accepted start.
- Latency with zero-wait memory (gnt always 1, rvalid one cycle after gnt), start accepted at cycle 0:
  - Read: beat k requested at cycle 1+2k; done at cycle 65.
  - Write: beat k granted at cycle 1+k; done at cycle 33.
- mem_rvalid outside RD_WAIT is ignored.

Decomposition:
- Shared package:
  - State encoding (3-bit localparams).
  - BEATS, BUS_W and DATA_W constants.
  - The address-increment constant 4.
- Sub-module dma_timeout_counter:
  - Load/clear/enable inputs and an expired output, parameterised by TIMEOUT.
  - Reused later by other bus masters.

Test Plan:
- Read: zero-wait memory, memory word at 0x1000+4k = 0xA5000000+k; pulse rx_start with rx_address = 0x1000 -> done at cycle 65, error = 0, rx_data[32k+31:32k] = 0xA5000000+k for all k.
- Write: tx_data with word k = k*0x01010101; tx_start at address 0x2003 -> 32 writes to 0x2000..0x207C with matching data, done at cycle 33.
- Wait states: random mem_gnt throttling and rvalid delay 0-5 cycles on read -> data identical to the zero-wait case; mem_addr stable while mem_req && !mem_gnt.
- Error: mem_err with rvalid on beat 7 -> done pulses, error = 1, rx_data unchanged from previous value; next rx_start clears error.
- Timeout / priority:
  - mem_gnt held 0 -> done after TIMEOUT cycles with error = 1.
  - rx_start and tx_start in the same cycle -> only the read executes.
  - rx_start while busy -> ignored.
- Reset at beat 10 of a write -> mem_req = 0 and idle = 1 immediately, no done pulse; a subsequent read completes normally.

Source files
------------

// File: rtl/dma_block_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dma_block_engine_pkg
// Brief   : Shared constants, state encoding and helpers for the block DMA
//           engine and its bus interfaces.
// Revision: 1.0 - initial release
// ============================================================================
package dma_block_engine_pkg;

    localparam int c_DATA_W   = 1024;
    localparam int c_BUS_W    = 32;
    localparam int c_BEATS    = c_DATA_W / c_BUS_W;
    localparam int c_ADDR_INC = 4;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT = 3'd2;
    localparam logic [2:0] c_ST_WR_REQ  = 3'd3;
    localparam logic [2:0] c_ST_FINISH  = 3'd4;

    // Force a byte address down to the containing 32-bit word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_block_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : dma_ctrl_if / dma_mem_if
// Brief   : Coprocessor-side block handshake and system memory word port.
//           master = the side that initiates transfers on that interface.
// Revision: 1.0 - initial release
// ============================================================================
interface dma_ctrl_if;
    logic                                       rx_start;
    logic [31:0]                                rx_address;
    logic [dma_block_engine_pkg::c_DATA_W-1:0]  rx_data;
    logic                                       tx_start;
    logic [31:0]                                tx_address;
    logic [dma_block_engine_pkg::c_DATA_W-1:0]  tx_data;
    logic                                       done;
    logic                                       idle;
    logic                                       error;

    modport master (
        output rx_start, rx_address, tx_start, tx_address, tx_data,
        input  rx_data, done, idle, error
    );
    modport slave (
        input  rx_start, rx_address, tx_start, tx_address, tx_data,
        output rx_data, done, idle, error
    );
endinterface

interface dma_mem_if;
    logic                                     mem_req;
    logic                                     mem_we;
    logic [31:0]                              mem_addr;
    logic [dma_block_engine_pkg::c_BUS_W-1:0] mem_wdata;
    logic                                     mem_gnt;
    logic                                     mem_rvalid;
    logic [dma_block_engine_pkg::c_BUS_W-1:0] mem_rdata;
    logic                                     mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/dma_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module  : dma_timeout_counter
// Brief   : Saturating wait counter; o_expired once TIMEOUT cycles counted.
//           Clear beats load, load beats enable.
// Revision: 1.0 - initial release
// ============================================================================
module dma_timeout_counter #(
    parameter  int TIMEOUT = 1024,
    localparam int c_CNT_W = $clog2(TIMEOUT + 1)
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               i_clear,
    input  wire logic               i_load,
    input  wire logic [c_CNT_W-1:0] i_load_value,
    input  wire logic               i_enable,
    output logic                    o_expired
);

    logic [c_CNT_W-1:0] r_count;

    assign o_expired = (r_count >= c_CNT_W'(TIMEOUT));

    // Count enabled cycles, holding at the limit so expiry stays asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_block_engine.sv
`default_nettype none
// ============================================================================
// Module  : dma_block_engine
// Brief   : Responder for 1024-bit block DMA; moves one block per request as
//           32 sequential word reads (RX) or writes (TX) on the memory port.
// Revision: 1.0 - initial release
// ============================================================================
module dma_block_engine
    import dma_block_engine_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int BUS_W   = c_BUS_W,
    parameter int TIMEOUT = 1024
) (
    input  wire logic  clk,
    input  wire logic  reset,
    dma_ctrl_if.slave  ctrl,
    dma_mem_if.master  mem
);

    localparam int c_NUM_BEATS = DATA_W / BUS_W;
    localparam int c_BEAT_W    = $clog2(c_NUM_BEATS);
    localparam int c_CNT_W     = $clog2(TIMEOUT + 1);

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [31:0]         r_base;
    logic [c_BEAT_W-1:0] r_beat;
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_error;

    logic                w_accept_rx;
    logic                w_accept_tx;
    logic                w_rd_beat;
    logic                w_wr_beat;
    logic                w_abort;
    logic                w_handshake;
    logic                w_mem_req;
    logic                w_mem_we;
    logic                w_last_beat;
    logic                w_expired;
    logic [31:0]         w_start_addr;
    logic [31:0]         w_beat_addr;
    logic [BUS_W-1:0]    w_shift_in;
    logic [DATA_W-1:0]   w_buf_shift;

    assign w_last_beat  = (r_beat == c_BEAT_W'(c_NUM_BEATS - 1));
    assign w_start_addr = ctrl.rx_start ? ctrl.rx_address : ctrl.tx_address;
    assign w_beat_addr  = r_base + (32'(r_beat) * 32'(c_ADDR_INC));
    // Reads fill from the top so beat 0 ends up in the low word; writes
    // drain the low word and shift zeros in.
    assign w_shift_in   = w_mem_we ? '0 : mem.mem_rdata;
    assign w_buf_shift  = {w_shift_in, r_buf[DATA_W-1:BUS_W]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state bus controls.
    always_comb begin
        w_state_next = r_state;
        w_accept_rx  = 1'b0;
        w_accept_tx  = 1'b0;
        w_rd_beat    = 1'b0;
        w_wr_beat    = 1'b0;
        w_abort      = 1'b0;
        w_handshake  = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (ctrl.rx_start) begin
                    w_accept_rx  = 1'b1;
                    w_state_next = c_ST_RD_REQ;
                end else if (ctrl.tx_start) begin
                    w_accept_tx  = 1'b1;
                    w_state_next = c_ST_WR_REQ;
                end
            end
            c_ST_RD_REQ: begin
                w_mem_req = 1'b1;
                if (mem.mem_gnt) begin
                    w_handshake  = 1'b1;
                    w_state_next = c_ST_RD_WAIT;
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = c_ST_FINISH;
                end
            end
            c_ST_RD_WAIT: begin
                if (mem.mem_rvalid) begin
                    w_handshake = 1'b1;
                    if (mem.mem_err) begin
                        w_abort      = 1'b1;
                        w_state_next = c_ST_FINISH;
                    end else begin
                        w_rd_beat    = 1'b1;
                        w_state_next = w_last_beat ? c_ST_FINISH : c_ST_RD_REQ;
                    end
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = c_ST_FINISH;
                end
            end
            c_ST_WR_REQ: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                if (mem.mem_gnt) begin
                    w_handshake = 1'b1;
                    if (mem.mem_err) begin
                        w_abort      = 1'b1;
                        w_state_next = c_ST_FINISH;
                    end else begin
                        w_wr_beat = 1'b1;
                        if (w_last_beat) begin
                            w_state_next = c_ST_FINISH;
                        end
                    end
                end else if (w_expired) begin
                    w_abort      = 1'b1;
                    w_state_next = c_ST_FINISH;
                end
            end
            c_ST_FINISH: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Transfer context: base address, beat index, shift buffer, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base  <= '0;
            r_beat  <= '0;
            r_buf   <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_accept_rx || w_accept_tx) begin
                r_base  <= word_align(w_start_addr);
                r_beat  <= '0;
                r_error <= 1'b0;
            end
            if (w_accept_tx) begin
                r_buf <= ctrl.tx_data;
            end
            if (w_rd_beat || w_wr_beat) begin
                r_buf <= w_buf_shift;
                if (!w_last_beat) begin
                    r_beat <= r_beat + c_BEAT_W'(1);
                end
            end
            if (w_abort) begin
                r_error <= 1'b1;
            end
        end
    end

    // Publish the assembled block only when the final read beat lands cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data <= '0;
        end else if (w_rd_beat && w_last_beat) begin
            r_rx_data <= w_buf_shift;
        end
    end

    // Wait budget restarts on every state change and every bus response.
    dma_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk          (clk),
        .reset        (reset),
        .i_clear      ((w_state_next != r_state) || w_handshake),
        .i_load       (1'b0),
        .i_load_value (c_CNT_W'(0)),
        .i_enable     (w_mem_req || (r_state == c_ST_RD_WAIT)),
        .o_expired    (w_expired)
    );

    assign ctrl.rx_data  = r_rx_data;
    assign ctrl.done     = (r_state == c_ST_FINISH);
    assign ctrl.idle     = (r_state == c_ST_IDLE) || (r_state == c_ST_FINISH);
    assign ctrl.error    = r_error;
    assign mem.mem_req   = w_mem_req;
    assign mem.mem_we    = w_mem_we;
    assign mem.mem_addr  = w_mem_req ? w_beat_addr : '0;
    assign mem.mem_wdata = w_mem_we ? r_buf[BUS_W-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_dma_block_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_dma_block_engine
// Brief   : Directed bench with a transfer-level reference model for the
//           block DMA engine and a configurable memory responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dma_block_engine;

    localparam int c_TIMEOUT = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dma_ctrl_if ctrl_if ();
    dma_mem_if  mem_if ();

    dma_block_engine #(
        .DATA_W  (1024),
        .BUS_W   (32),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (ctrl_if),
        .mem   (mem_if)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder configuration: gnt_mode 0 = always, 1 = random, 2 = never.
    int gnt_mode  = 0;
    int max_delay = 0;
    int err_beat  = -1;
    int rd_beats  = 0;
    int wr_beats  = 0;
    bit rd_pend   = 0;
    int rd_cnt    = 0;
    logic [31:0] rd_addr;
    logic [31:0] wr_mem [logic [31:0]];

    // Reference model state.
    bit            m_active  = 0;
    bit            m_we      = 0;
    bit            m_err_exp = 0;
    logic [31:0]   m_base    = '0;
    int            m_beat    = 0;
    logic [1023:0] m_tx      = '0;
    logic [1023:0] m_new_rx  = '0;
    logic [1023:0] m_rx      = '0;
    int            t_start   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA500_0000 + ((a - 32'h1000) >> 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int k = 0; k < 32; k++) begin
                if (act[32*k +: 32] !== exp[32*k +: 32]) begin
                    $display("FAIL %s: word %0d got %h expected %h (cycle %0d)",
                             nm, k, act[32*k +: 32], exp[32*k +: 32], cyc);
                    break;
                end
            end
        end
    endtask

    // Memory responder: decides gnt for the current cycle, returns read data
    // after 0..max_delay extra cycles, injects mem_err on the chosen beat.
    initial begin
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;
        mem_if.mem_err    = 1'b0;
        forever begin
            @(negedge clk);
            mem_if.mem_gnt    = 1'b0;
            mem_if.mem_rvalid = 1'b0;
            mem_if.mem_rdata  = '0;
            mem_if.mem_err    = 1'b0;
            if (reset) begin
                rd_pend = 0;
                continue;
            end
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mem_if.mem_rvalid = 1'b1;
                    mem_if.mem_rdata  = mem_word(rd_addr);
                    if (rd_beats == err_beat) mem_if.mem_err = 1'b1;
                    rd_beats++;
                    rd_pend = 0;
                end else begin
                    rd_cnt--;
                end
            end else if (mem_if.mem_req) begin
                bit g;
                g = (gnt_mode == 0) ? 1'b1 :
                    (gnt_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
                mem_if.mem_gnt = g;
                if (g) begin
                    if (mem_if.mem_we) begin
                        wr_mem[mem_if.mem_addr] = mem_if.mem_wdata;
                        if (wr_beats == err_beat) mem_if.mem_err = 1'b1;
                        wr_beats++;
                    end else begin
                        rd_pend = 1;
                        rd_cnt  = (max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0;
                        rd_addr = mem_if.mem_addr;
                    end
                end
            end
        end
    end

    // Compare process: every granted beat, every done pulse, rx_data every cycle.
    initial begin
        logic [31:0] prev_addr;
        bit          prev_stall;
        prev_addr  = '0;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall && mem_if.mem_req)
                chk("addr_hold", mem_if.mem_addr, prev_addr);
            prev_stall = mem_if.mem_req && !mem_if.mem_gnt;
            prev_addr  = mem_if.mem_addr;
            if (mem_if.mem_req && mem_if.mem_gnt) begin
                chk("req_active", 32'(m_active), 32'd1);
                chk("beat_we", 32'(mem_if.mem_we), 32'(m_we));
                chk("beat_addr", mem_if.mem_addr, m_base + 32'(4 * m_beat));
                if (m_we && m_beat < 32)
                    chk("beat_wdata", mem_if.mem_wdata, m_tx[32*m_beat +: 32]);
                m_beat++;
            end
            if (ctrl_if.done) begin
                chk("done_active", 32'(m_active), 32'd1);
                chk("done_idle", 32'(ctrl_if.idle), 32'd1);
                chk("done_error", 32'(ctrl_if.error), 32'(m_err_exp));
                if (!m_err_exp) begin
                    chk("done_beats", 32'(m_beat), 32'd32);
                    if (!m_we) m_rx = m_new_rx;
                end
                m_active = 0;
            end
            chk_blk("rx_data", ctrl_if.rx_data, m_rx);
        end
    end

    task automatic start_read(input logic [31:0] a, input bit also_tx);
        @(negedge clk);
        rd_beats = 0;
        wr_beats = 0;
        ctrl_if.rx_start   = 1'b1;
        ctrl_if.rx_address = a;
        if (also_tx) begin
            ctrl_if.tx_start   = 1'b1;
            ctrl_if.tx_address = 32'h0000_5550;
        end
        m_active  = 1;
        m_we      = 0;
        m_base    = a & ~32'd3;
        m_beat    = 0;
        m_err_exp = (err_beat >= 0 && err_beat < 32) || (gnt_mode == 2);
        for (int k = 0; k < 32; k++) m_new_rx[32*k +: 32] = mem_word(m_base + 32'(4 * k));
        t_start = cyc;
        @(negedge clk);
        ctrl_if.rx_start = 1'b0;
        ctrl_if.tx_start = 1'b0;
    endtask

    task automatic start_write(input logic [31:0] a, input logic [1023:0] blk);
        @(negedge clk);
        rd_beats = 0;
        wr_beats = 0;
        wr_mem.delete();
        ctrl_if.tx_start   = 1'b1;
        ctrl_if.tx_address = a;
        ctrl_if.tx_data    = blk;
        m_active  = 1;
        m_we      = 1;
        m_base    = a & ~32'd3;
        m_beat    = 0;
        m_tx      = blk;
        m_err_exp = (err_beat >= 0 && err_beat < 32) || (gnt_mode == 2);
        t_start   = cyc;
        @(negedge clk);
        ctrl_if.tx_start = 1'b0;
        ctrl_if.tx_data  = '1;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (ctrl_if.done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            total++;
            bad++;
            $display("FAIL done_wait: no done within %0d cycles", budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation stalled (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            dc;
        bit            found;
        logic [1023:0] blk;

        ctrl_if.rx_start   = 1'b0;
        ctrl_if.rx_address = '0;
        ctrl_if.tx_start   = 1'b0;
        ctrl_if.tx_address = '0;
        ctrl_if.tx_data    = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_idle", 32'(ctrl_if.idle), 32'd1);
        chk("rst_done", 32'(ctrl_if.done), 32'd0);
        chk("rst_error", 32'(ctrl_if.error), 32'd0);
        chk("rst_req", 32'(mem_if.mem_req), 32'd0);
        chk("rst_we", 32'(mem_if.mem_we), 32'd0);
        chk("rst_addr", mem_if.mem_addr, 32'd0);
        chk("rst_wdata", mem_if.mem_wdata, 32'd0);
        chk_blk("rst_rx_data", ctrl_if.rx_data, 1024'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Zero-wait read
        start_read(32'h1000, 1'b0);
        #1 chk("idle_drops", 32'(ctrl_if.idle), 32'd0);
        wait_done(200, dc);
        chk("rd_latency", 32'(dc - t_start), 32'd65);
        chk("rd_word0", ctrl_if.rx_data[31:0], 32'hA500_0000);
        chk("rd_word31", ctrl_if.rx_data[1023:992], 32'hA500_001F);
        chk("rd_error", 32'(ctrl_if.error), 32'd0);

        // Zero-wait write from an unaligned address
        for (int k = 0; k < 32; k++) blk[32*k +: 32] = 32'(k) * 32'h0101_0101;
        start_write(32'h2003, blk);
        wait_done(200, dc);
        chk("wr_latency", 32'(dc - t_start), 32'd33);
        chk("wr_count", 32'(wr_mem.num()), 32'd32);
        chk("wr_first", wr_mem.exists(32'h2000) ? wr_mem[32'h2000] : 32'hDEAD_BEEF, 32'h0000_0000);
        chk("wr_beat5", wr_mem.exists(32'h2014) ? wr_mem[32'h2014] : 32'hDEAD_BEEF, 32'h0505_0505);
        chk("wr_last", wr_mem.exists(32'h207C) ? wr_mem[32'h207C] : 32'hDEAD_BEEF, 32'h1F1F_1F1F);

        // Throttled grants and delayed read data
        gnt_mode  = 1;
        max_delay = 5;
        start_read(32'h1000, 1'b0);
        wait_done(2000, dc);
        chk("ws_word7", ctrl_if.rx_data[255:224], 32'hA500_0007);
        gnt_mode  = 0;
        max_delay = 0;

        // Bus error on read beat 7: rx_data keeps the previous block
        err_beat = 7;
        start_read(32'h1400, 1'b0);
        wait_done(200, dc);
        chk("err_flag", 32'(ctrl_if.error), 32'd1);
        chk("err_rx_kept", ctrl_if.rx_data[31:0], 32'hA500_0000);
        err_beat = -1;
        @(negedge clk);
        #1 chk("err_sticky", 32'(ctrl_if.error), 32'd1);
        start_read(32'h1000, 1'b0);
        #1 chk("err_cleared", 32'(ctrl_if.error), 32'd0);
        wait_done(200, dc);

        // Grant never arrives: timeout abort
        gnt_mode = 2;
        start_read(32'h3000, 1'b0);
        wait_done(c_TIMEOUT + 100, dc);
        chk("tmo_in_range", 32'((dc - t_start) >= c_TIMEOUT && (dc - t_start) <= c_TIMEOUT + 4), 32'd1);
        chk("tmo_error", 32'(ctrl_if.error), 32'd1);
        gnt_mode = 0;

        // Simultaneous starts: read wins
        start_read(32'h1080, 1'b1);
        wait_done(200, dc);
        chk("prio_latency", 32'(dc - t_start), 32'd65);
        chk("prio_word0", ctrl_if.rx_data[31:0], 32'hA500_0020);

        // Start while busy is ignored
        start_read(32'h1000, 1'b0);
        repeat (6) @(negedge clk);
        ctrl_if.rx_start   = 1'b1;
        ctrl_if.rx_address = 32'h9000;
        ctrl_if.tx_start   = 1'b1;
        ctrl_if.tx_address = 32'h9100;
        @(negedge clk);
        ctrl_if.rx_start = 1'b0;
        ctrl_if.tx_start = 1'b0;
        wait_done(200, dc);
        chk("busy_latency", 32'(dc - t_start), 32'd65);

        // Reset during beat 10 of a write
        for (int k = 0; k < 32; k++) blk[32*k +: 32] = ~(32'(k) * 32'h0011_2233);
        start_write(32'h2000, blk);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mem_if.mem_req && mem_if.mem_addr == 32'h2028) begin
                found = 1;
                break;
            end
        end
        chk("reached_beat10", 32'(found), 32'd1);
        reset    = 1'b1;
        m_active = 0;
        m_rx     = '0;
        #1;
        chk("mid_rst_req", 32'(mem_if.mem_req), 32'd0);
        chk("mid_rst_idle", 32'(ctrl_if.idle), 32'd1);
        chk("mid_rst_done", 32'(ctrl_if.done), 32'd0);
        chk("mid_rst_addr", mem_if.mem_addr, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1 chk("no_done_after_rst", 32'(ctrl_if.done), 32'd0);
        end
        start_read(32'h1000, 1'b0);
        wait_done(200, dc);
        chk("post_rst_latency", 32'(dc - t_start), 32'd65);
        chk("post_rst_word31", ctrl_if.rx_data[1023:992], 32'hA500_001F);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
